mac_tag_verify: RTL

Receive-side counterpart of the serial MAC tag generator. Accepts a data word X, a key/mask word R and a received tag T. Recomputes the 32-bit tag bit-serially, one bit per clock, using the same bit equation as the generator. Compares the result against T and reports match, first mismatching bit and mismatch count. Sits on the ECC/MAC receive path between the word buffer and the error-handling logic.

---
 rtl/mac_pkg.sv | 11 +
 rtl/mac_tag_bit.sv | 18 +
 rtl/mac_tag_verify.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the serial MAC tag generator and verifier.
package mac_pkg;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/mac_tag_bit.sv
// One bit of the serial MAC tag equation. The generator instantiates the same
// cell, so both ends of the link compute each bit identically.
module mac_tag_bit (
  input  logic x_i,
  input  logic x_im1,
  input  logic r_i,
  input  logic r_im1,
  input  logic x0r0,
  input  logic p,
  output logic y_i
);

  // Key-pair, data-pair and prefix terms on top of the bit-0 product.
  always_comb begin
    y_i = x0r0 ^ (r_i & r_im1) ^ (x_i & x_im1) ^ p;
  end

endmodule

// File: rtl/mac_tag_verify.sv
// Receive-side MAC tag check: recomputes the tag one bit per clock, compares
// it against the received tag and reports match, first bad bit and bad-bit count.
module mac_tag_verify
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] tag,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [WIDTH-1:0] y,
  output logic [4:0]       first_err,
  output logic [5:0]       err_count
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] x_q, r_q, tag_q;
  logic [IDX_W-1:0] idx;
  logic             p_q;
  logic             seen_q;
  logic             accept;
  logic             last_bit;
  logic             x_im1, r_im1;
  logic             y_bit;
  logic             err_bit;
  logic [5:0]       err_count_nx;

  // Handshake and per-bit decode; bit -1 is treated as 0.
  always_comb begin
    accept       = (state == IDLE) && start;
    last_bit     = (idx == IDX_W'(WIDTH - 1));
    x_im1        = 1'b0;
    r_im1        = 1'b0;
    if (idx != '0) begin
      x_im1 = x_q[idx - 1'b1];
      r_im1 = r_q[idx - 1'b1];
    end
    err_bit      = y_bit ^ tag_q[idx];
    err_count_nx = err_count + 6'(err_bit);
  end

  mac_tag_bit u_bit (
    .x_i   (x_q[idx]),
    .x_im1 (x_im1),
    .r_i   (r_q[idx]),
    .r_im1 (r_im1),
    .x0r0  (x_q[0] & r_q[0]),
    .p     (p_q),
    .y_i   (y_bit)
  );

  // Next-state logic: one word per pass through IDLE -> RUN -> DONE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_bit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Operand capture, serial datapath and registered results.
  // match is resolved on the last RUN edge (using the count including bit 31)
  // so it is valid in the same cycle as the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      match     <= 1'b0;
      y         <= '0;
      first_err <= '0;
      err_count <= '0;
      x_q       <= '0;
      r_q       <= '0;
      tag_q     <= '0;
      idx       <= '0;
      p_q       <= 1'b0;
      seen_q    <= 1'b0;
    end else begin
      busy <= (state_nx != IDLE);
      done <= (state_nx == DONE);
      if (accept) begin
        x_q       <= x;
        r_q       <= r;
        tag_q     <= tag;
        idx       <= '0;
        p_q       <= 1'b0;
        seen_q    <= 1'b0;
        y         <= '0;
        err_count <= '0;
        first_err <= '0;
        match     <= 1'b0;
      end else if (state == RUN) begin
        y[idx] <= y_bit;
        if (err_bit) begin
          err_count <= err_count_nx;
          if (!seen_q) begin
            first_err <= idx;
            seen_q    <= 1'b1;
          end
        end
        if (idx != '0) p_q <= p_q ^ (x_q[idx] & r_q[idx]);
        idx <= idx + 1'b1;
        if (last_bit) match <= (err_count_nx == '0);
      end
    end
  end

endmodule
